// File: rtl/mult_seq_pkg.sv
// Shared types for the multiplier operand sequencer: widths, FSM state encoding
// and the queued operand-pair layout.
package mult_seq_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int PROD_WIDTH = 2 * DATA_WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_B = 3'd1,
        ST_LOAD_A = 3'd2,
        ST_WAIT   = 3'd3,
        ST_RESULT = 3'd4
    } state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] b;
    } op_pair_t;

endpackage

// File: rtl/mult_seq_fifo.sv
// Synchronous FIFO for operand pairs. Pointers carry an extra wrap bit so that
// full and empty are distinguished without a separate occupancy counter.
module mult_seq_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             wr_en;
    logic             rd_en;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A write into a full FIFO is legal when the head leaves in the same cycle.
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;
    assign rdata = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/mult_operand_sequencer.sv
// Feeds queued (A,B) pairs to the shift-add multiplier and returns each product.
// Optional watchdog enabled by defining MULT_SEQ_TIMEOUT_EN.
module mult_operand_sequencer
    import mult_seq_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
`ifdef MULT_SEQ_TIMEOUT_EN
    ,
    parameter int TIMEOUT    = 64
`endif
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_op_a,
    input  logic [DATA_WIDTH-1:0] s_op_b,
    output logic [DATA_WIDTH-1:0] m_data_input,
    output logic                  m_start,
    input  logic                  m_done,
    input  logic [DATA_WIDTH-1:0] m_acc,
    input  logic [DATA_WIDTH-1:0] m_a_reg,
    output logic                  r_valid,
    input  logic                  r_ready,
    output logic [PROD_WIDTH-1:0] r_product,
    output logic                  r_err,
    output logic                  busy,
    output state_t                dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // valid, once raised, holds with stable data until that transfer; ready may
    // change freely and never depends combinationally on the partner's valid.

    state_t                state_q, state_d;
    logic                  start_q, start_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] a_hold_q, a_hold_d;
    logic                  rvalid_q, rvalid_d;
    logic [PROD_WIDTH-1:0] prod_q, prod_d;
    logic                  err_q, err_d;
    logic                  timeout_hit;

    op_pair_t              fifo_wdata;
    op_pair_t              fifo_head;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;

    assign fifo_wdata = '{a: s_op_a, b: s_op_b};
    assign fifo_push  = s_valid && s_ready;

    mult_seq_fifo #(
        .WIDTH (PROD_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .push    (fifo_push),
        .wdata   (fifo_wdata),
        .pop     (fifo_pop),
        .rdata   (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

`ifdef MULT_SEQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counts every cycle spent in LOAD_A/WAIT; LOAD_A is cycle 0.
    always_comb begin
        cnt_d = '0;
        if (state_q == ST_LOAD_A || state_q == ST_WAIT) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign timeout_hit = (state_q == ST_WAIT) && (cnt_q == CNT_W'(TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        start_d  = 1'b0;
        data_d   = data_q;
        a_hold_d = a_hold_q;
        rvalid_d = rvalid_q;
        prod_d   = prod_q;
        err_d    = err_q;
        fifo_pop = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && !rvalid_q) begin
                    fifo_pop = 1'b1;
                    data_d   = fifo_head.b;
                    a_hold_d = fifo_head.a;
                    start_d  = 1'b1;
                    state_d  = ST_LOAD_B;
                end
            end
            ST_LOAD_B: begin
                data_d  = a_hold_q;
                state_d = ST_LOAD_A;
            end
            ST_LOAD_A: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (m_done) begin
                    prod_d   = {m_acc, m_a_reg};
                    err_d    = 1'b0;
                    rvalid_d = 1'b1;
                    state_d  = ST_RESULT;
                end else if (timeout_hit) begin
                    prod_d   = '0;
                    err_d    = 1'b1;
                    rvalid_d = 1'b1;
                    state_d  = ST_RESULT;
                end
            end
            ST_RESULT: begin
                if (r_ready) begin
                    rvalid_d = 1'b0;
                    err_d    = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            start_q  <= 1'b0;
            data_q   <= '0;
            a_hold_q <= '0;
            rvalid_q <= 1'b0;
            prod_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            start_q  <= start_d;
            data_q   <= data_d;
            a_hold_q <= a_hold_d;
            rvalid_q <= rvalid_d;
            prod_q   <= prod_d;
            err_q    <= err_d;
        end
    end

    assign s_ready      = !fifo_full;
    assign m_start      = start_q;
    assign m_data_input = data_q;
    assign r_valid      = rvalid_q;
    assign r_product    = prod_q;
    assign r_err        = err_q;
    assign busy         = (state_q != ST_IDLE);
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_mult_operand_sequencer.sv
// Directed and randomized bench for mult_operand_sequencer with a behavioural
// multiplier responder and an expected-product queue.
module tb_mult_operand_sequencer;
    import mult_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_valid, s_ready;
    logic [7:0]  s_op_a, s_op_b;
    logic [7:0]  m_data_input;
    logic        m_start, m_done;
    logic [7:0]  m_acc, m_a_reg;
    logic        r_valid, r_ready;
    logic [15:0] r_product;
    logic        r_err, busy;
    state_t      dbg_state;

    logic        resp_done, spur_done;
    logic [7:0]  resp_acc, resp_a, spur_acc, spur_a;

    int          checks = 0;
    int          passed = 0;
    int          fails  = 0;
    int unsigned start_count = 0;
    bit          stall = 1'b0;
    bit          never = 1'b0;

    logic [15:0] exp_q[$];
    op_pair_t    pair_q[$];

    always #5 clk = ~clk;

    assign m_done  = resp_done | spur_done;
    assign m_acc   = spur_done ? spur_acc : resp_acc;
    assign m_a_reg = spur_done ? spur_a   : resp_a;

    mult_operand_sequencer dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_op_a       (s_op_a),
        .s_op_b       (s_op_b),
        .m_data_input (m_data_input),
        .m_start      (m_start),
        .m_done       (m_done),
        .m_acc        (m_acc),
        .m_a_reg      (m_a_reg),
        .r_valid      (r_valid),
        .r_ready      (r_ready),
        .r_product    (r_product),
        .r_err        (r_err),
        .busy         (busy),
        .dbg_state    (dbg_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Multiplier stand-in: latches B on start, A on the next cycle, then
    // answers with the true product after a random latency.
    initial begin
        resp_done = 1'b0;
        resp_acc  = '0;
        resp_a    = '0;
        forever begin
            @(negedge clk);
            if (rst_n && m_start) begin
                op_pair_t    p;
                logic [7:0]  b_seen, a_seen;
                int          lat;
                int          guard;
                start_count++;
                chk("pair_expected_at_start", 32'(pair_q.size() != 0), 32'd1);
                p = '0;
                if (pair_q.size() != 0) p = pair_q.pop_front();
                b_seen = m_data_input;
                chk("start_data_b", b_seen, p.b);
                @(negedge clk);
                a_seen = m_data_input;
                chk("start_one_cycle", m_start, 1'b0);
                chk("load_data_a", a_seen, p.a);
                if (!never) begin
                    lat = $urandom_range(1, 6);
                    repeat (lat) @(posedge clk);
                    guard = 0;
                    while (stall && guard < 2000) begin
                        @(posedge clk);
                        guard++;
                    end
                    #1;
                    {resp_acc, resp_a} = 16'(b_seen) * 16'(a_seen);
                    resp_done = 1'b1;
                    @(posedge clk);
                    #1 resp_done = 1'b0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded its time budget");
        $fatal(1, "global timeout");
    end

    task automatic push_pair(input logic [7:0] a, input logic [7:0] b);
        int       n;
        op_pair_t p;
        n = 0;
        @(negedge clk);
        s_valid = 1'b1;
        s_op_a  = a;
        s_op_b  = b;
        while (!s_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("push_accepted", s_ready, 1'b1);
        p.a = a;
        p.b = b;
        pair_q.push_back(p);
        exp_q.push_back(16'(a) * 16'(b));
        @(posedge clk);
        #1 s_valid = 1'b0;
    endtask

    task automatic get_result(input logic experr, input int ready_delay, output logic [15:0] got);
        int          n;
        logic [15:0] expp;
        n = 0;
        @(negedge clk);
        while (!r_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("result_arrived", r_valid, 1'b1);
        chk("expected_queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
        expp = '0;
        if (exp_q.size() != 0) expp = exp_q.pop_front();
        if (experr) expp = '0;
        got = r_product;
        chk("r_product", r_product, expp);
        chk("r_err", r_err, experr);
        repeat (ready_delay) begin
            @(negedge clk);
            chk("product_stable", r_product, expp);
            chk("valid_held", r_valid, 1'b1);
        end
        r_ready = 1'b1;
        @(posedge clk);
        #1 r_ready = 1'b0;
        @(negedge clk);
        chk("valid_cleared", r_valid, 1'b0);
        chk("err_cleared", r_err, 1'b0);
    endtask

    initial begin
        logic [15:0] got;
        int          n;
        int unsigned sc;

        s_valid   = 1'b0;
        s_op_a    = '0;
        s_op_b    = '0;
        r_ready   = 1'b0;
        spur_done = 1'b0;
        spur_acc  = '0;
        spur_a    = '0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_s_ready", s_ready, 1'b1);
        chk("rst_m_start", m_start, 1'b0);
        chk("rst_m_data_input", m_data_input, 8'd0);
        chk("rst_r_valid", r_valid, 1'b0);
        chk("rst_r_product", r_product, 16'd0);
        chk("rst_r_err", r_err, 1'b0);
        chk("rst_busy", busy, 1'b0);
        rst_n = 1'b1;

        // Single pair 13 x 11
        push_pair(8'd13, 8'd11);
        get_result(1'b0, 0, got);
        chk("t1_product_const", got, 16'h008F);
        chk("t1_idle_after", busy, 1'b0);

        // Five back-to-back pushes against a stalled multiplier
        stall = 1'b1;
        for (int i = 0; i < 5; i++) push_pair(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        @(negedge clk);
        chk("t2_full_s_ready", s_ready, 1'b0);
        chk("t2_busy", busy, 1'b1);
        stall = 1'b0;
        for (int i = 0; i < 5; i++) get_result(1'b0, $urandom_range(0, 3), got);

        // 255 x 255 held by a slow consumer, another pair queued behind it
        push_pair(8'd255, 8'd255);
        push_pair(8'd1, 8'd2);
        n = 0;
        while (!r_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        sc = start_count;
        get_result(1'b0, 10, got);
        chk("t3_product_const", got, 16'hFE01);
        chk("t3_no_start_while_result", start_count, sc);
        get_result(1'b0, 0, got);

        // Reset while waiting for done
        stall = 1'b1;
        push_pair(8'd7, 8'd9);
        push_pair(8'd3, 8'd4);
        n = 0;
        while (dbg_state != ST_WAIT && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("t4_reached_wait", 32'(dbg_state == ST_WAIT), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t4_rst_s_ready", s_ready, 1'b1);
        chk("t4_rst_m_start", m_start, 1'b0);
        chk("t4_rst_m_data_input", m_data_input, 8'd0);
        chk("t4_rst_r_valid", r_valid, 1'b0);
        chk("t4_rst_r_product", r_product, 16'd0);
        chk("t4_rst_r_err", r_err, 1'b0);
        chk("t4_rst_busy", busy, 1'b0);
        pair_q.delete();
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        stall = 1'b0;
        repeat (10) begin
            @(negedge clk);
            chk("t4_late_done_ignored", r_valid, 1'b0);
            chk("t4_fifo_empty_idle", busy, 1'b0);
        end

        // Spurious done while idle
        @(negedge clk);
        spur_acc  = 8'hAA;
        spur_a    = 8'h55;
        spur_done = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("t6_spurious_no_valid", r_valid, 1'b0);
            chk("t6_spurious_no_capture", r_product, 16'd0);
        end
        spur_done = 1'b0;

`ifdef MULT_SEQ_TIMEOUT_EN
        // Watchdog: multiplier never answers, then the next pair proceeds
        never = 1'b1;
        push_pair(8'd6, 8'd7);
        get_result(1'b1, 0, got);
        never = 1'b0;
        push_pair(8'd8, 8'd9);
        get_result(1'b0, 0, got);
        chk("t5_after_timeout_product", got, 16'd72);
`endif

        // Randomized traffic with random consumer back-pressure
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    push_pair(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
                end
            end
            begin
                logic [15:0] g;
                for (int j = 0; j < 20; j++) get_result(1'b0, $urandom_range(0, 4), g);
            end
        join
        chk("rand_queue_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
